lwc_segment_loader: RTL and testbench



---
 rtl/lwc_pkg.sv | 25 ++
 rtl/lwc_block_pad.sv | 25 ++
 rtl/lwc_segment_loader.sv | 141 ++++++++++++++
 tb/tb_lwc_segment_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwc_pkg.sv
// rtl/lwc_pkg.sv - shared LWC segment codes, header layout and loader states
package lwc_pkg;

  localparam logic [3:0] SEG_AD   = 4'h1;
  localparam logic [3:0] SEG_PT   = 4'h4;
  localparam logic [3:0] SEG_CT   = 4'h5;
  localparam logic [3:0] SEG_TAG  = 4'h8;
  localparam logic [3:0] SEG_KEY  = 4'hC;
  localparam logic [3:0] SEG_NPUB = 4'hD;

  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_TYPE_LSB = 28;
  localparam int HDR_EOI      = 26;
  localparam int HDR_EOT      = 25;
  localparam int HDR_LAST     = 24;

  typedef enum logic [1:0] {HDR, LOAD, EMIT} ld_state_t;

  // True for the segment types the Romulus mode datapath understands
  function automatic logic seg_type_known(input logic [3:0] t);
    return (t == SEG_AD) || (t == SEG_PT) || (t == SEG_CT) ||
           (t == SEG_TAG) || (t == SEG_KEY) || (t == SEG_NPUB);
  endfunction

endpackage

// File: rtl/lwc_block_pad.sv
// rtl/lwc_block_pad.sv - Romulus-style block padding (zero fill plus length byte)
module lwc_block_pad
  import lwc_pkg::*;
#(
  parameter int BLOCK_W = 128
) (
  input  logic [BLOCK_W-1:0]          i_blk,
  input  logic [$clog2(BLOCK_W/8):0]  i_nbytes,
  output logic [BLOCK_W-1:0]          o_blk
);

  localparam int NB = BLOCK_W / 8;

  // Partial block: clear bytes past nbytes, then put nbytes in the final byte
  always_comb begin
    o_blk = i_blk;
    if (int'(i_nbytes) < NB) begin
      for (int k = 0; k < NB; k++) begin
        if (k >= int'(i_nbytes)) o_blk[BLOCK_W-1-8*k -: 8] = 8'h00;
      end
      o_blk[7:0] = 8'(i_nbytes);
    end
  end

endmodule

// File: rtl/lwc_segment_loader.sv
// rtl/lwc_segment_loader.sv - LWC PDI header parser and padded block assembler
module lwc_segment_loader
  import lwc_pkg::*;
#(
  parameter int W       = 32,
  parameter int BLOCK_W = 128,
  parameter int LEN_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 pdi_data,
  input  logic                         pdi_valid,
  output logic                         pdi_ready,
  output logic [BLOCK_W-1:0]           blk_data,
  output logic [$clog2(BLOCK_W/8):0]   blk_nbytes,
  output logic                         blk_pad,
  output logic [3:0]                   blk_type,
  output logic                         blk_last,
  output logic                         blk_eoi,
  output logic                         blk_eot,
  output logic                         blk_valid,
  input  logic                         blk_ready
);

  localparam int NB = BLOCK_W / 8;
  localparam int BW = W / 8;
  localparam int CW = $clog2(NB) + 1;
  localparam logic [1:0] HB_LAST = 2'(32 / W - 1);

  ld_state_t            r_state;
  logic [31:0]          r_hdr;
  logic [1:0]           r_hbeat;
  logic [BLOCK_W-1:0]   r_blk;
  logic [CW-1:0]        r_boff;
  logic [LEN_W-1:0]     r_rem;
  logic                 r_last;

  logic                 w_beat;
  logic                 w_emit;
  logic [32+W-1:0]      w_cat;
  logic [31:0]          w_hdr_next;
  logic [LEN_W-1:0]     w_len;
  logic [CW-1:0]        w_take;
  logic [W-1:0]         w_wmask;
  logic [BLOCK_W-1:0]   w_word_top;
  logic [BLOCK_W-1:0]   w_ins;
  logic [CW-1:0]        w_boff_next;
  logic [LEN_W-1:0]     w_rem_next;
  logic [BLOCK_W-1:0]   w_padded;
  logic                 w_unused_hdr;

  assign w_beat      = pdi_valid && pdi_ready;
  assign w_emit      = (r_state == EMIT);
  // Header beats arrive MSB first, so shift the previous beats up
  assign w_cat       = {r_hdr, pdi_data};
  assign w_hdr_next  = w_cat[31:0];
  assign w_len       = w_hdr_next[LEN_W-1:0];
  assign w_take      = (r_rem < LEN_W'(BW)) ? CW'(r_rem) : CW'(BW);
  assign w_boff_next = r_boff + w_take;
  assign w_rem_next  = r_rem - LEN_W'(w_take);
  // Word is aligned to the block MSBs, then slid down to the current byte offset
  assign w_word_top  = BLOCK_W'(pdi_data & w_wmask) << (BLOCK_W - W);
  assign w_ins       = w_word_top >> {r_boff, 3'b000};
  assign w_unused_hdr = ^{w_cat[32+W-1:32], r_hdr[27], r_hdr[HDR_LAST:0]};

  // Keep only the leading bytes of the beat that still belong to the segment
  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < BW; i++) begin
      if (i < int'(w_take)) w_wmask[W-1-8*i -: 8] = 8'hFF;
    end
  end

  // Segment FSM: header collection, byte loading, block hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HDR;
      r_hdr   <= '0;
      r_hbeat <= '0;
      r_blk   <= '0;
      r_boff  <= '0;
      r_rem   <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        HDR: begin
          if (w_beat) begin
            r_hdr <= w_hdr_next;
            if (r_hbeat == HB_LAST) begin
              r_hbeat <= '0;
              r_rem   <= w_len;
              r_last  <= (w_len == '0);
              r_state <= (w_len == '0) ? EMIT : LOAD;
            end else begin
              r_hbeat <= r_hbeat + 2'd1;
            end
          end
        end
        LOAD: begin
          if (w_beat) begin
            r_blk  <= r_blk | w_ins;
            r_boff <= w_boff_next;
            r_rem  <= w_rem_next;
            if ((w_boff_next == CW'(NB)) || (w_rem_next == '0)) begin
              r_last  <= (w_rem_next == '0);
              r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            r_blk   <= '0;
            r_boff  <= '0;
            r_last  <= 1'b0;
            r_state <= r_last ? HDR : LOAD;
          end
        end
        default: r_state <= HDR;
      endcase
    end
  end

  lwc_block_pad #(
    .BLOCK_W (BLOCK_W)
  ) u_pad (
    .i_blk    (r_blk),
    .i_nbytes (r_boff),
    .o_blk    (w_padded)
  );

  assign pdi_ready  = !w_emit;
  assign blk_valid  = w_emit;
  assign blk_data   = w_emit ? w_padded : '0;
  assign blk_nbytes = w_emit ? r_boff : '0;
  assign blk_pad    = w_emit && (r_boff < CW'(NB));
  assign blk_type   = w_emit ? r_hdr[HDR_TYPE_MSB:HDR_TYPE_LSB] : 4'h0;
  assign blk_last   = w_emit && r_last;
  assign blk_eoi    = blk_last && r_hdr[HDR_EOI];
  assign blk_eot    = blk_last && r_hdr[HDR_EOT];

endmodule

// File: tb/tb_lwc_segment_loader.sv
// tb/tb_lwc_segment_loader.sv - scoreboard bench for lwc_segment_loader at W=32/16/8
module tb_lwc_segment_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  p32_data = '0;
  logic [15:0]  p16_data = '0;
  logic [7:0]   p8_data  = '0;
  logic         p32_valid = 1'b0, p16_valid = 1'b0, p8_valid = 1'b0;
  logic         p32_ready, p16_ready, p8_ready;
  logic [127:0] b32_data, b16_data, b8_data;
  logic [4:0]   b32_nb, b16_nb, b8_nb;
  logic         b32_pad, b16_pad, b8_pad;
  logic [3:0]   b32_type, b16_type, b8_type;
  logic         b32_last, b16_last, b8_last;
  logic         b32_eoi, b16_eoi, b8_eoi;
  logic         b32_eot, b16_eot, b8_eot;
  logic         b32_valid, b16_valid, b8_valid;
  logic         b32_ready = 1'b1, b16_ready = 1'b1, b8_ready = 1'b1;

  lwc_segment_loader #(.W(32), .BLOCK_W(128), .LEN_W(16)) u32 (
    .clk(clk), .rst(rst), .pdi_data(p32_data), .pdi_valid(p32_valid), .pdi_ready(p32_ready),
    .blk_data(b32_data), .blk_nbytes(b32_nb), .blk_pad(b32_pad), .blk_type(b32_type),
    .blk_last(b32_last), .blk_eoi(b32_eoi), .blk_eot(b32_eot), .blk_valid(b32_valid),
    .blk_ready(b32_ready));

  lwc_segment_loader #(.W(16), .BLOCK_W(128), .LEN_W(16)) u16 (
    .clk(clk), .rst(rst), .pdi_data(p16_data), .pdi_valid(p16_valid), .pdi_ready(p16_ready),
    .blk_data(b16_data), .blk_nbytes(b16_nb), .blk_pad(b16_pad), .blk_type(b16_type),
    .blk_last(b16_last), .blk_eoi(b16_eoi), .blk_eot(b16_eot), .blk_valid(b16_valid),
    .blk_ready(b16_ready));

  lwc_segment_loader #(.W(8), .BLOCK_W(128), .LEN_W(16)) u8 (
    .clk(clk), .rst(rst), .pdi_data(p8_data), .pdi_valid(p8_valid), .pdi_ready(p8_ready),
    .blk_data(b8_data), .blk_nbytes(b8_nb), .blk_pad(b8_pad), .blk_type(b8_type),
    .blk_last(b8_last), .blk_eoi(b8_eoi), .blk_eot(b8_eot), .blk_valid(b8_valid),
    .blk_ready(b8_ready));

  typedef struct {
    logic [127:0] data;
    logic [4:0]   nb;
    logic         pad;
    logic [3:0]   typ;
    logic         last;
    logic         eoi;
    logic         eot;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  sb[$];
  int          sel = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          beats_acc = 0;
  bit          drv_done = 1'b0;

  logic [127:0] m_data;
  logic [4:0]   m_nb;
  logic         m_pad, m_last, m_eoi, m_eot, m_valid, m_bready, m_pready;
  logic [3:0]   m_type;

  always_comb begin
    m_data = b32_data; m_nb = b32_nb; m_pad = b32_pad; m_type = b32_type;
    m_last = b32_last; m_eoi = b32_eoi; m_eot = b32_eot; m_valid = b32_valid;
    m_bready = b32_ready; m_pready = p32_ready;
    if (sel == 1) begin
      m_data = b16_data; m_nb = b16_nb; m_pad = b16_pad; m_type = b16_type;
      m_last = b16_last; m_eoi = b16_eoi; m_eot = b16_eot; m_valid = b16_valid;
      m_bready = b16_ready; m_pready = p16_ready;
    end else if (sel == 2) begin
      m_data = b8_data; m_nb = b8_nb; m_pad = b8_pad; m_type = b8_type;
      m_last = b8_last; m_eoi = b8_eoi; m_eot = b8_eot; m_valid = b8_valid;
      m_bready = b8_ready; m_pready = p8_ready;
    end
  end

  // Scoreboard monitor: every block handshake pops one expected block
  always @(negedge clk) begin
    if (!rst && m_valid && m_bready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL blk_unexpected: got data=%h nb=%0d, required no block", m_data, m_nb);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({m_data, m_nb, m_pad, m_type, m_last, m_eoi, m_eot} !==
            {e.data, e.nb, e.pad, e.typ, e.last, e.eoi, e.eot}) begin
          n_err++;
          $display("FAIL blk[dut%0d]: got data=%h nb=%0d pad=%b type=%h last=%b eoi=%b eot=%b, required data=%h nb=%0d pad=%b type=%h last=%b eoi=%b eot=%b",
                   sel, m_data, m_nb, m_pad, m_type, m_last, m_eoi, m_eot,
                   e.data, e.nb, e.pad, e.typ, e.last, e.eoi, e.eot);
        end
      end
    end
  end

  function automatic int bw_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 2 : 1;
  endfunction

  task automatic set_pdi(input logic [31:0] w, input logic v);
    case (sel)
      0: begin p32_data = w;       p32_valid = v; end
      1: begin p16_data = w[15:0]; p16_valid = v; end
      default: begin p8_data = w[7:0]; p8_valid = v; end
    endcase
  endtask

  task automatic drive_beat(input logic [31:0] w);
    int t;
    @(negedge clk);
    set_pdi(w, 1'b1);
    t = 0;
    while (!m_pready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_vec++; n_err++;
      $display("FAIL pdi_accept_timeout: got ready=%b, required 1 within 300 cycles", m_pready);
    end else begin
      @(posedge clk);
      beats_acc++;
    end
    #1 set_pdi(32'h0, 1'b0);
  endtask

  task automatic push_exp(input logic [127:0] d, input logic [4:0] nb, input logic pad,
                          input logic [3:0] typ, input logic last, input logic eoi, input logic eot);
    exp_t e;
    e.data = d; e.nb = nb; e.pad = pad; e.typ = typ; e.last = last; e.eoi = eoi; e.eot = eot;
    exp_q.push_back(e);
  endtask

  // Reference model: slice the first len bytes of sb into padded 16-byte blocks
  task automatic model_push(input logic [31:0] hdr);
    int len, s, n;
    logic [127:0] d;
    logic last;
    len = int'(hdr[15:0]);
    s = 0;
    do begin
      n = (len - s > 16) ? 16 : len - s;
      d = '0;
      for (int k = 0; k < n; k++) d[127-8*k -: 8] = sb[s+k];
      if (n < 16) d[7:0] = 8'(n);
      last = (s + 16 >= len);
      push_exp(d, 5'(n), (n < 16), hdr[31:28], last, last & hdr[26], last & hdr[25]);
      s += 16;
    end while (s < len);
  endtask

  task automatic send_seg(input logic [31:0] hdr, input bit use_model);
    int bw, len, nbeats, idx;
    logic [31:0] w;
    bw = bw_of(sel);
    len = int'(hdr[15:0]);
    if (use_model) model_push(hdr);
    for (int b = 0; b < 4 / bw; b++) drive_beat(hdr >> (32 - 8 * bw * (b + 1)));
    nbeats = (len + bw - 1) / bw;
    for (int b = 0; b < nbeats; b++) begin
      w = '0;
      for (int i = 0; i < bw; i++) begin
        idx = b * bw + i;
        w = (w << 8) | ((idx < sb.size()) ? 32'(sb[idx]) : 32'hEE);
      end
      drive_beat(w);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d blocks outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(output bit ok);
    int t;
    t = 0;
    while (!m_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = m_valid;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL blk_valid_timeout: got blk_valid=0, required 1 within 300 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({b32_valid, p32_ready, b32_data, b32_nb, b32_pad, b32_type, b32_last, b32_eoi, b32_eot} !==
        {1'b0, 1'b1, 128'h0, 5'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_w32: got valid=%b ready=%b data=%h nb=%0d pad=%b, required valid=0 ready=1 others 0",
               b32_valid, p32_ready, b32_data, b32_nb, b32_pad);
    end
    n_vec++;
    if ({b16_valid, p16_ready, b8_valid, p8_ready} !== 4'b0101) begin
      n_err++;
      $display("FAIL reset_w16_w8: got %b, required 0101", {b16_valid, p16_ready, b8_valid, p8_ready});
    end
  endtask

  task automatic test_full_block();
    sel = 0;
    sb.delete();
    for (int i = 0; i < 16; i++) sb.push_back(8'(i));
    push_exp(128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1);
    send_seg(32'h1700_0010, 1'b0);
    wait_drain();
  endtask

  task automatic test_partial_pad();
    sel = 0;
    sb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hAA, 8'hBB, 8'hCC};
    push_exp(128'h11223344_55000000_00000000_00000005, 5'd5, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    send_seg(32'h1000_0005, 1'b0);
    wait_drain();
  endtask

  task automatic test_empty_w8();
    bit ok;
    sel = 2;
    sb.delete();
    b8_ready = 1'b0;
    push_exp(128'h0, 5'd0, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1);
    send_seg(32'h4600_0000, 1'b0);
    wait_valid(ok);
    if (ok) begin
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if ({p8_ready, b8_valid} !== 2'b01) begin
          n_err++;
          $display("FAIL empty_stall: got ready=%b valid=%b, required ready=0 valid=1", p8_ready, b8_valid);
        end
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1 b8_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_two_blocks_w16();
    sel = 1;
    sb.delete();
    for (int i = 0; i < 20; i++) sb.push_back(8'(8'hA0 + i));
    send_seg(32'h5000_0014, 1'b1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] snap;
    int t;
    sel = 0;
    sb.delete();
    for (int i = 0; i < 32; i++) sb.push_back(8'(i * 3 + 1));
    model_push(32'h4000_0020);
    b32_ready = 1'b0;
    beats_acc = 0;
    drv_done = 1'b0;
    fork
      begin
        send_seg(32'h4000_0020, 1'b0);
        drv_done = 1'b1;
      end
    join_none
    wait_valid(ok);
    snap = b32_data;
    if (ok) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        n_vec++;
        if ({p32_ready, b32_valid, b32_data, beats_acc} !== {1'b0, 1'b1, snap, 32'd5}) begin
          n_err++;
          $display("FAIL stall_cycle%0d: got ready=%b valid=%b data=%h beats=%0d, required ready=0 valid=1 data=%h beats=5",
                   c, p32_ready, b32_valid, b32_data, beats_acc, snap);
        end
      end
    end
    @(posedge clk);
    #1 b32_ready = 1'b1;
    t = 0;
    while (!drv_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!drv_done) begin
      n_vec++; n_err++;
      $display("FAIL stall_driver_timeout: got driver busy, required done");
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    sel = 0;
    sb.delete();
    for (int i = 0; i < 16; i++) sb.push_back(8'(8'hF0 - i));
    send_seg(32'hC000_0010, 1'b1);
    sb.delete();
    for (int i = 0; i < 12; i++) sb.push_back(8'(8'h30 + 7 * i));
    send_seg(32'hD600_000C, 1'b1);
    wait_drain();
    sel = 2;
    sb = '{8'h9A, 8'hBC, 8'hDE};
    send_seg(32'h8200_0003, 1'b1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    sel = 0;
    drive_beat(32'h1700_0010);
    drive_beat(32'h00010203);
    drive_beat(32'h04050607);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({b32_valid, p32_ready, b32_nb} !== {1'b0, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%b ready=%b nb=%0d, required valid=0 ready=1 nb=0",
               b32_valid, p32_ready, b32_nb);
    end
    sb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_exp(128'hDEADBEEF_00000000_00000000_00000004, 5'd4, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    send_seg(32'h1000_0004, 1'b0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_partial_pad();
    test_empty_w8();
    test_two_blocks_w16();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
